// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } lsu_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_RD,
        S_WR,
        S_RESP
    } lsu_state_t;

    function automatic logic is_store(input lsu_op_t op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic is_sub_word(input lsu_op_t op);
        return (op != OP_LW) && (op != OP_SW);
    endfunction

    function automatic logic is_word(input lsu_op_t op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic is_half(input lsu_op_t op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic misaligned(input lsu_op_t op, input logic [1:0] lo);
        return (is_half(op) && lo[0]) || (is_word(op) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_if.sv
// CPU request/response and word-memory signals of the load/store unit.
interface lsu_if #(parameter int ADDR_W = 10);
    import lsu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    lsu_op_t           req_op;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // slave is the LSU; master is the CPU plus memory environment around it
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/lsu_lane_mux.sv
// Little-endian lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_lane_mux
    import lsu_pkg::*;
(
    input  lsu_op_t     op_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v  = word_i[{lane_i, 3'b000} +: 8];
        half_v  = word_i[{lane_i[1], 4'b0000} +: 16];
        load_o  = word_i;
        merge_o = word_i;
        case (op_i)
            OP_LB:   load_o = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_o = {24'd0, byte_v};
            OP_LH:   load_o = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_o = {16'd0, half_v};
            OP_SB:   merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            OP_SH:   merge_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed CPU loads/stores onto a word memory; SH/SB via read-modify-write.
// Define MISALIGN_TRAP_EN to trap misaligned requests instead of force-aligning them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 10
)
(
    input  logic clk,
    input  logic rst_n,
    lsu_if.slave bus
);

    localparam int AW = ADDR_W + 2;

    lsu_state_t  state_q, state_d;
    lsu_op_t     op_q, op_d;
    logic [AW-1:0] addr_q, addr_d, req_addr_al;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] load_data, merge_data;
    logic        unused_addr_hi;
`ifdef MISALIGN_TRAP_EN
    logic        err_q, err_d;
`endif

    assign unused_addr_hi = ^bus.req_addr[31:AW];

    lsu_lane_mux u_lane_mux (
        .op_i    (op_q),
        .lane_i  (addr_q[1:0]),
        .word_i  (bus.mem_rdata),
        .wdata_i (wdata_q),
        .load_o  (load_data),
        .merge_o (merge_data)
    );

    always_comb begin
        req_addr_al = bus.req_addr[AW-1:0];
        if (is_word(bus.req_op)) begin
            req_addr_al[1:0] = 2'b00;
        end else if (is_half(bus.req_op)) begin
            req_addr_al[0] = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        rdata_d = rdata_q;
`ifdef MISALIGN_TRAP_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    addr_d  = req_addr_al;
                    wdata_d = bus.req_wdata;
                    rdata_d = 32'd0;
                    state_d = (is_store(bus.req_op) && is_sub_word(bus.req_op)) ? S_RD : S_ACCESS;
`ifdef MISALIGN_TRAP_EN
                    err_d   = misaligned(bus.req_op, bus.req_addr[1:0]);
                    if (err_d) begin
                        state_d = S_RESP;
                    end
`endif
                end
            end
            S_ACCESS: begin
                if (!is_store(op_q)) begin
                    rdata_d = load_data;
                end
                state_d = S_RESP;
            end
            S_RD: begin
                word_d  = merge_data;
                state_d = S_WR;
            end
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_LW;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            word_q  <= 32'd0;
            rdata_q <= 32'd0;
`ifdef MISALIGN_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
`ifdef MISALIGN_TRAP_EN
            err_q   <= err_d;
`endif
        end
    end

    // Memory-side outputs decode straight from state so reset kills a write immediately
    always_comb begin
        bus.req_ready  = (state_q == S_IDLE);
        bus.resp_valid = (state_q == S_RESP);
        bus.resp_rdata = (state_q == S_RESP) ? rdata_q : 32'd0;
        bus.mem_addr   = '0;
        bus.mem_we     = 1'b0;
        bus.mem_wdata  = 32'd0;
        if (state_q == S_ACCESS || state_q == S_RD || state_q == S_WR) begin
            bus.mem_addr = addr_q[AW-1:2];
        end
        if (state_q == S_ACCESS && op_q == OP_SW) begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = wdata_q;
        end else if (state_q == S_WR) begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = word_q;
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign bus.resp_err = (state_q == S_RESP) && err_q;
`else
    assign bus.resp_err = 1'b0;
`endif

endmodule
